// File: rtl/hbmc_pkg.sv
// hbmc_pkg: shared B-channel response codes and write-response FSM encoding
package hbmc_pkg;
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_RESP} state_e;
endpackage

// File: rtl/hbmc_axi_bresp_gen_if.sv
// hbmc_axi_bresp_gen_if: AXI4 write-response (B) channel
// Ports: bid/bresp/bvalid from slave to master, bready from master to slave.
interface hbmc_axi_bresp_gen_if #(parameter int AXI_ID_WIDTH = 8);
  logic [AXI_ID_WIDTH-1:0] bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  modport slave  (output bid, bresp, bvalid, input bready);
  modport master (input bid, bresp, bvalid, output bready);
endinterface

// File: rtl/hbmc_done_queue.sv
// hbmc_done_queue: ring of burst-completion error flags awaiting a B response
// Ports: clk, rstn (async active-low); wr_done/wr_err push a completion;
// pop retires the head; count, head_err, done_full and sticky ovf_err report state.
module hbmc_done_queue #(
  parameter int CNT_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_done,
  input  logic               wr_err,
  input  logic               pop,
  output logic [CNT_WIDTH:0] count,
  output logic               head_err,
  output logic               done_full,
  output logic               ovf_err
);
  localparam int DEPTH = 1 << CNT_WIDTH;
  logic [CNT_WIDTH:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0]   ring;
  logic               push;
  // One extra pointer bit distinguishes full from empty; wrap is plain modulo.
  assign count     = wr_ptr - rd_ptr;
  assign done_full = count == (CNT_WIDTH+1)'(DEPTH);
  assign push      = wr_done && !done_full;
  assign head_err  = ring[rd_ptr[CNT_WIDTH-1:0]];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ring    <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) begin
        ring[wr_ptr[CNT_WIDTH-1:0]] <= wr_err;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_done && done_full) ovf_err <= 1'b1;
    end
  end
endmodule

// File: rtl/hbmc_axi_bresp_gen.sv
// hbmc_axi_bresp_gen: pairs burst completions with queued AWIDs and issues in-order B responses
// Ports: clk, rstn (async active-low); wr_done/wr_err completion pulses;
// done_full/ovf_err queue status; fifo_rd_* ID FIFO read side (non-FWFT);
// s_axi B-channel slave interface.
module hbmc_axi_bresp_gen
  import hbmc_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 8,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_done,
  input  logic                    wr_err,
  output logic                    done_full,
  output logic                    ovf_err,
  input  logic [AXI_ID_WIDTH-1:0] fifo_rd_dout,
  input  logic                    fifo_rd_empty,
  output logic                    fifo_rd_ena,
  hbmc_axi_bresp_gen_if.slave     s_axi
);
  if (AXI_ID_WIDTH > 8) begin : g_bad_width
    $error("hbmc_axi_bresp_gen: AXI_ID_WIDTH must not exceed 8");
  end
  state_e             state, nxt;
  logic [CNT_WIDTH:0] count;
  logic               head_err, pop, avail;
  hbmc_done_queue #(.CNT_WIDTH(CNT_WIDTH)) u_queue (
    .clk      (clk),
    .rstn     (rstn),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .pop      (pop),
    .count    (count),
    .head_err (head_err),
    .done_full(done_full),
    .ovf_err  (ovf_err)
  );
  // A response can start only when both its completion and its ID are present;
  // an empty ID FIFO simply stalls.
  assign avail = count != '0 && !fifo_rd_empty;
  always_comb begin
    nxt         = state;
    fifo_rd_ena = 1'b0;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        fifo_rd_ena = avail;
        nxt         = avail ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        pop = 1'b1;
        nxt = ST_RESP;
      end
      ST_RESP: if (s_axi.bready) begin
        fifo_rd_ena = avail;
        nxt         = avail ? ST_FETCH : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end
  // bvalid is high exactly while in ST_RESP, so it drops for the fetch cycle
  // between back-to-back responses and no stale beat is ever re-offered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      s_axi.bvalid <= 1'b0;
      s_axi.bid    <= '0;
      s_axi.bresp  <= BRESP_OKAY;
    end else begin
      state        <= nxt;
      s_axi.bvalid <= nxt == ST_RESP;
      if (state == ST_FETCH) begin
        s_axi.bid   <= fifo_rd_dout;
        s_axi.bresp <= head_err ? BRESP_SLVERR : BRESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_hbmc_axi_bresp_gen.sv
// tb_hbmc_axi_bresp_gen: scoreboard bench for the write-response generator
module tb_hbmc_axi_bresp_gen;
  import hbmc_pkg::*;
  logic       clk = 1'b0, rstn = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
  logic       done_full, ovf_err, fifo_rd_ena;
  logic       fifo_rd_empty = 1'b1;
  logic [7:0] fifo_rd_dout = 8'h00;
  int         n_vec = 0, n_err = 0, cyc = 0, ena_cnt = 0;
  logic [7:0] idq[$], wq[$], exp_id[$];
  logic       exp_err[$];
  int         hs_cyc[$];
  always #5 clk = ~clk;
  hbmc_axi_bresp_gen_if #(.AXI_ID_WIDTH(8)) s_axi ();
  hbmc_axi_bresp_gen #(.AXI_ID_WIDTH(8), .CNT_WIDTH(5)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_done      (wr_done),
    .wr_err       (wr_err),
    .done_full    (done_full),
    .ovf_err      (ovf_err),
    .fifo_rd_dout (fifo_rd_dout),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_ena  (fifo_rd_ena),
    .s_axi        (s_axi)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Standard (non-FWFT) ID FIFO: writes become visible one cycle later,
  // read data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_ena && idq.size() != 0) fifo_rd_dout <= idq.pop_front();
    while (wq.size() != 0) idq.push_back(wq.pop_front());
    fifo_rd_empty <= idq.size() == 0;
  end
  always @(negedge clk) if (rstn) begin
    if (fifo_rd_ena) ena_cnt++;
    if (s_axi.bvalid && s_axi.bready) begin
      if (exp_id.size() == 0 || exp_err.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        chk("bid", 32'(s_axi.bid), 32'(exp_id.pop_front()));
        chk("bresp", 32'(s_axi.bresp), exp_err.pop_front() ? 32'(BRESP_SLVERR) : 32'(BRESP_OKAY));
      end
      hs_cyc.push_back(cyc);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fifo_push(input logic [7:0] id);
    wq.push_back(id);
    exp_id.push_back(id);
  endtask
  task automatic pulse(input logic e, input bit keep);
    wr_done = 1'b1;
    wr_err  = e;
    if (keep) exp_err.push_back(e);
    tick();
    wr_done = 1'b0;
    wr_err  = 1'b0;
  endtask
  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_id.size() != 0 || exp_err.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_id.size() + exp_err.size()), 0);
  endtask
  task automatic wait_bvalid(input int budget, input string tag);
    int n = 0;
    while (!s_axi.bvalid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(s_axi.bvalid), 1);
  endtask
  initial begin
    bit stable;
    s_axi.bready = 1'b1;
    repeat (3) tick();
    chk("rst_bvalid", 32'(s_axi.bvalid), 0);
    chk("rst_bid", 32'(s_axi.bid), 0);
    chk("rst_bresp", 32'(s_axi.bresp), 0);
    chk("rst_ena", 32'(fifo_rd_ena), 0);
    chk("rst_full", 32'(done_full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    rstn = 1'b1;
    tick();
    fifo_push(8'h3A);
    tick();
    tick();
    pulse(1'b0, 1'b1);
    chk("single_ena_c1", 32'(fifo_rd_ena), 1);
    chk("single_bv_c1", 32'(s_axi.bvalid), 0);
    tick();
    chk("single_ena_c2", 32'(fifo_rd_ena), 0);
    chk("single_bv_c2", 32'(s_axi.bvalid), 0);
    tick();
    chk("single_bv_c3", 32'(s_axi.bvalid), 1);
    chk("single_bid_c3", 32'(s_axi.bid), 32'h3A);
    wait_drain(20, "single_drain");
    for (int i = 1; i <= 3; i++) fifo_push(8'(i));
    tick();
    tick();
    hs_cyc.delete();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    wait_drain(40, "b2b_drain");
    chk("b2b_count", 32'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 2);
      chk("b2b_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 2);
    end
    s_axi.bready = 1'b0;
    fifo_push(8'h44);
    tick();
    tick();
    ena_cnt = 0;
    pulse(1'b1, 1'b1);
    wait_bvalid(10, "bp_bvalid");
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (s_axi.bid !== 8'h44 || s_axi.bresp !== BRESP_SLVERR || s_axi.bvalid !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    s_axi.bready = 1'b1;
    wait_drain(20, "bp_drain");
    chk("bp_ena_once", 32'(ena_cnt), 1);
    s_axi.bready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pulse(1'($urandom_range(0, 1)), 1'b1);
      if (i == 30) chk("ovf_full_at31", 32'(done_full), 0);
    end
    chk("ovf_full_at32", 32'(done_full), 1);
    chk("ovf_err_at32", 32'(ovf_err), 0);
    pulse(1'b1, 1'b0);
    chk("ovf_err_at33", 32'(ovf_err), 1);
    chk("ovf_full_at33", 32'(done_full), 1);
    for (int i = 0; i < 32; i++) fifo_push(8'h80 + 8'(i));
    s_axi.bready = 1'b1;
    wait_drain(400, "ovf_drain");
    chk("ovf_full_after", 32'(done_full), 0);
    ena_cnt = 0;
    pulse(1'b0, 1'b1);
    repeat (5) tick();
    chk("stall_no_ena", 32'(ena_cnt), 0);
    chk("stall_no_bv", 32'(s_axi.bvalid), 0);
    fifo_push(8'h07);
    tick();
    chk("stall_ena", 32'(fifo_rd_ena), 1);
    tick();
    chk("stall_bv_k2", 32'(s_axi.bvalid), 0);
    tick();
    chk("stall_bv_k3", 32'(s_axi.bvalid), 1);
    chk("stall_bid_k3", 32'(s_axi.bid), 32'h07);
    wait_drain(20, "stall_drain");
    s_axi.bready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_push(8'h10 + 8'(i));
    tick();
    tick();
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
    wait_bvalid(10, "mid_bvalid");
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_bv_drop", 32'(s_axi.bvalid), 0);
    chk("mid_ovf_clr", 32'(ovf_err), 0);
    chk("mid_full_clr", 32'(done_full), 0);
    idq.delete();
    wq.delete();
    exp_id.delete();
    exp_err.delete();
    tick();
    tick();
    rstn = 1'b1;
    s_axi.bready = 1'b1;
    fifo_push(8'h55);
    tick();
    tick();
    hs_cyc.delete();
    pulse(1'b0, 1'b1);
    wait_drain(20, "mid_drain");
    chk("mid_one_resp", 32'(hs_cyc.size()), 1);
    chk("mid_ovf_after", 32'(ovf_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
